// File: rtl/demux_1to4_stream.sv
// One-input, four-lane stream demultiplexer with a single holding register per lane.
// Each lane keeps its own count of completed output transfers.
module demux_1to4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [31:0]        out_count
);

    function automatic logic [7:0] wrap_inc(input logic [7:0] c);
        return c + 8'd1;
    endfunction

    logic [WIDTH-1:0] data_p1 [4];
    logic [3:0]       vld_p1;
    logic [7:0]       cnt_p1  [4];
    logic [3:0]       load;
    logic [3:0]       out_xfer;

    // A lane can accept when it is empty or its word leaves in the same cycle.
    assign in_ready = ~vld_p1[in_sel] | out_ready[in_sel];
    assign out_xfer = vld_p1 & out_ready;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign load[g] = in_valid & in_ready & (in_sel == 2'(g));
        assign out_data[g*WIDTH +: WIDTH] = data_p1[g];
        assign out_count[g*8 +: 8]        = cnt_p1[g];
    end

    assign out_valid = vld_p1;

    // ---- stage p1: lane holding registers and transfer counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_p1[i] <= '0;
                cnt_p1[i]  <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_p1[i] <= in_data;
                    vld_p1[i]  <= 1'b1;
                end else if (out_xfer[i]) begin
                    vld_p1[i]  <= 1'b0;
                end
                if (out_xfer[i]) begin
                    cnt_p1[i] <= wrap_inc(cnt_p1[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Scoreboard bench for demux_1to4_stream: accepted words are queued per lane,
// a monitor pops and compares them as lanes present output transfers.
module tb_demux_1to4_stream;
    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [WIDTH-1:0]   in_data = '0;
    logic [1:0]         in_sel = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready = '0;
    logic [31:0]        out_count;

    always #5 clk = ~clk;

    demux_1to4_stream #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
    );

    typedef logic [WIDTH-1:0] word_q_t [$];
    word_q_t          exp_q [4];
    logic [WIDTH-1:0] shown [4];
    int               cnt   [4];
    int               checks = 0;
    int               errors = 0;
    bit               started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are registers, sampled 1 time unit after the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (started) begin
                for (int i = 0; i < 4; i++) begin
                    logic [WIDTH-1:0] want;
                    want = (exp_q[i].size() != 0) ? exp_q[i][0] : shown[i];
                    check($sformatf("valid%0d", i), 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
                    check($sformatf("data%0d", i), 32'(out_data[i*WIDTH +: WIDTH]), 32'(want));
                    check($sformatf("count%0d", i), 32'(out_count[i*8 +: 8]), 32'(cnt[i] % 256));
                    if (!rst && exp_q[i].size() != 0 && out_ready[i]) begin
                        shown[i] = exp_q[i].pop_front();
                        cnt[i]   = cnt[i] + 1;
                    end
                end
            end
        end
    end

    // One cycle of stimulus; the reference decides acceptance from lane occupancy.
    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [WIDTH-1:0] d, input logic [3:0] ordy);
        logic exp_rdy;
        @(negedge clk);
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
        #2;
        exp_rdy = (exp_q[s].size() == 0) || ordy[s];
        if (started) check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                exp_q[i].delete();
                shown[i] = '0;
                cnt[i]   = 0;
            end
            started = 1'b1;
        end else if (v && exp_rdy) begin
            exp_q[s].push_back(d);
        end
    endtask

    task automatic idle(input logic [3:0] ordy);
        step(1'b0, 1'b0, 2'd0, '0, ordy);
    endtask

    initial begin
        step(1'b1, 1'b0, 2'd0, '0, 4'b0000);
        idle(4'b0000);

        // Routing to all four lanes with every consumer stalled
        step(1'b0, 1'b1, 2'd0, 8'hA0, 4'b0000);
        step(1'b0, 1'b1, 2'd1, 8'hA1, 4'b0000);
        step(1'b0, 1'b1, 2'd2, 8'hA2, 4'b0000);
        step(1'b0, 1'b1, 2'd3, 8'hA3, 4'b0000);
        idle(4'b0000);

        // Backpressure on lane 2, then re-steer to an emptied lane 1
        idle(4'b0010);
        step(1'b0, 1'b1, 2'd2, 8'h55, 4'b0000);
        step(1'b0, 1'b1, 2'd1, 8'h55, 4'b0000);
        idle(4'b0000);

        // Zero-bubble replacement on lane 0
        step(1'b0, 1'b1, 2'd0, 8'h11, 4'b0001);
        step(1'b0, 1'b1, 2'd0, 8'h22, 4'b0001);
        idle(4'b0000);

        // Drain lane 3
        idle(4'b1000);
        idle(4'b0000);

        // Counter wrap through lane 1 after a clean reset
        step(1'b1, 1'b0, 2'd0, '0, 4'b0000);
        for (int k = 0; k < 256; k++) step(1'b0, 1'b1, 2'd1, WIDTH'(k), 4'b0010);
        idle(4'b0010);
        idle(4'b0000);

        // Reset with all lanes full and a handshake offered
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2'(k), WIDTH'(8'hC0 + k), 4'b0000);
        step(1'b1, 1'b1, 2'd2, 8'h77, 4'b1111);
        idle(4'b0000);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom), 2'($urandom),
                 WIDTH'($urandom), 4'($urandom));
        end
        idle(4'b1111);
        idle(4'b0000);
        idle(4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
